// File: rtl/pe_bus_arbiter.sv
// Round-robin arbiter for the shared PE bus, with bounded burst lock and 1-cycle registered delivery.
// Optional stall counter port enabled by defining PE_BUS_ARB_STATS_EN.
module pe_bus_arbiter #(
    parameter int unsigned log_num_pe = 3,
    parameter int unsigned data_len   = 16,
    parameter int unsigned burst_max  = 4
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          eoc,
    input  logic [(1 << log_num_pe)*data_len-1:0]         pe_bus_data_out,
    input  logic [(1 << log_num_pe)*(log_num_pe+1)-1:0]   pe_bus_data_out_v,
    output logic [(1 << log_num_pe)-1:0]                  pe_bus_contention,
    output logic [data_len-1:0]                           pe_bus_data_in,
    output logic [(1 << log_num_pe)-1:0]                  pe_bus_data_in_v,
    output logic [log_num_pe-1:0]                         pe_bus_grant_id
`ifdef PE_BUS_ARB_STATS_EN
    ,
    output logic [31:0]                                   pe_bus_stall_cnt
`endif
);

    localparam int unsigned num_pe  = 1 << log_num_pe;
    localparam int unsigned idx_len = log_num_pe + 1;
    localparam int unsigned cnt_w   = $clog2(burst_max + 1);

    typedef logic [log_num_pe-1:0] pe_id_t;
    typedef logic [num_pe-1:0]     pe_vec_t;
    typedef logic [cnt_w-1:0]      cnt_t;
    typedef logic [data_len-1:0]   word_t;
    typedef enum logic [0:0] {IDLE, LOCK} state_t;

    state_t  state;
    pe_id_t  rr_ptr;
    pe_id_t  lock_id;
    cnt_t    burst_cnt;

    pe_vec_t req;
    pe_id_t  dest [num_pe];
    word_t   word [num_pe];
    logic    search_hit;
    pe_id_t  search_id;
    logic    owner_hold;
    logic    grant_v;
    pe_id_t  win_id;
    pe_vec_t grant_oh;

    // Unpack per-PE request, destination and word fields
    always_comb begin
        req = '0;
        for (int i = 0; i < num_pe; i++) begin
            req[i]  = pe_bus_data_out_v[i*idx_len + idx_len - 1];
            dest[i] = pe_bus_data_out_v[i*idx_len +: log_num_pe];
            word[i] = pe_bus_data_out[i*data_len +: data_len];
        end
    end

    // First requester at or above rr_ptr, wrapping through the top PE back to 0
    always_comb begin
        search_hit = 1'b0;
        search_id  = '0;
        for (int k = 0; k < num_pe; k++) begin
            if (!search_hit && req[rr_ptr + pe_id_t'(k)]) begin
                search_hit = 1'b1;
                search_id  = rr_ptr + pe_id_t'(k);
            end
        end
    end

    assign owner_hold = (state == LOCK) && req[lock_id];

    // Same-cycle grant; eoc and reset suppress every grant
    always_comb begin
        grant_v = 1'b0;
        win_id  = lock_id;
        if (reset && !eoc) begin
            if (owner_hold) begin
                grant_v = 1'b1;
                win_id  = lock_id;
            end else if (search_hit) begin
                grant_v = 1'b1;
                win_id  = search_id;
            end
        end
        grant_oh          = grant_v ? (pe_vec_t'(1) << win_id) : '0;
        pe_bus_contention = reset ? (req & ~grant_oh) : '0;
    end

    // Arbiter state and registered delivery
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            lock_id          <= '0;
            burst_cnt        <= '0;
            pe_bus_data_in   <= '0;
            pe_bus_data_in_v <= '0;
            pe_bus_grant_id  <= '0;
        end else begin
            if (grant_v) begin
                pe_bus_data_in   <= word[win_id];
                pe_bus_data_in_v <= pe_vec_t'(1) << dest[win_id];
                pe_bus_grant_id  <= win_id;
            end else begin
                pe_bus_data_in_v <= '0;
            end

            if (eoc) begin
                state     <= IDLE;
                rr_ptr    <= '0;
                burst_cnt <= '0;
            end else if (owner_hold) begin
                // Release the lock once the burst budget is spent
                if (burst_cnt + cnt_t'(1) == cnt_t'(burst_max)) begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end else begin
                    burst_cnt <= burst_cnt + cnt_t'(1);
                end
            end else if (search_hit) begin
                rr_ptr <= search_id + pe_id_t'(1);
                if (burst_max > 1) begin
                    state     <= LOCK;
                    lock_id   <= search_id;
                    burst_cnt <= cnt_t'(1);
                end else begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
            end else begin
                state     <= IDLE;
                burst_cnt <= '0;
            end
        end
    end

`ifdef PE_BUS_ARB_STATS_EN
    // Saturating count of cycles in which any requester lost arbitration
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pe_bus_stall_cnt <= '0;
        end else if (eoc) begin
            pe_bus_stall_cnt <= '0;
        end else if ((|pe_bus_contention) && (pe_bus_stall_cnt != 32'hFFFF_FFFF)) begin
            pe_bus_stall_cnt <= pe_bus_stall_cnt + 32'd1;
        end
    end
`else
    // Stall counter not built in this configuration
`endif

endmodule
